// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and a memory-wait FSM.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/wait performance counters.
module hazard_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_reg_write,
   input  logic [1:0] ex_result_src,
   input  logic       ex_redirect,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       stall_pc,
   output logic       stall_if_id,
   output logic       stall_id_ex,
   output logic       stall_ex_mem,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic [1:0] state,
   output logic       err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_wait_cnt
`endif
);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StMemWait = 2'b01,
      StErr     = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] Limit = CNT_W'(WAIT_LIMIT);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic load_use;
   logic mem_stall;
   logic in_run;
   logic lu_stall;
   logic redir_flush;
   logic hold_all;

   assign load_use = (ex_result_src == 2'b01) && ex_reg_write && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   assign mem_stall = mem_req && !mem_ready;
   assign in_run    = (state_q == StRun);

   // Priority in RUN: memory wait, then redirect, then load-use. Other states freeze everything.
   assign lu_stall    = rst_n && in_run && !mem_stall && !ex_redirect && load_use;
   assign redir_flush = rst_n && in_run && !mem_stall && ex_redirect;
   assign hold_all    = rst_n && (!in_run || mem_stall);

   always_comb begin
      stall_pc     = hold_all || lu_stall;
      stall_if_id  = hold_all || lu_stall;
      stall_id_ex  = hold_all;
      stall_ex_mem = hold_all;
      flush_if_id  = redir_flush;
      flush_id_ex  = redir_flush || lu_stall;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            StRun: begin
               if (mem_stall) begin
                  state_q <= StMemWait;
                  cnt_q   <= CNT_W'(1);
               end
            end
            StMemWait: begin
               if (mem_ready) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
               end else if (cnt_q == Limit) begin
                  state_q <= StErr;
                  err_q   <= 1'b1;
               end else if (cnt_q < Limit) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Unused encoding 2'b11 collapses into ERR.
            default: state_q <= StErr;
         endcase
      end
   end

   assign state = state_q;
   assign err   = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;
   logic [31:0] perf_wait_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         perf_wait_q  <= '0;
      end else begin
         if (lu_stall)                perf_stall_q <= perf_stall_q + 32'd1;
         if (redir_flush)             perf_flush_q <= perf_flush_q + 32'd1;
         if (state_q == StMemWait)    perf_wait_q  <= perf_wait_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
   assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (WAIT_LIMIT=4), table vectors plus FSM sequences.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_redirect, mem_req, mem_ready;
   logic [1:0] ex_result_src;
   logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex;
   logic [1:0] state;
   logic       err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .WAIT_LIMIT(4),
      .CNT_W     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_result_src(ex_result_src),
      .ex_redirect  (ex_redirect),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .stall_pc     (stall_pc),
      .stall_if_id  (stall_if_id),
      .stall_id_ex  (stall_id_ex),
      .stall_ex_mem (stall_ex_mem),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .state        (state),
      .err          (err)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt),
      .perf_wait_cnt (perf_wait_cnt)
`endif
   );

   // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex}
   localparam logic [5:0] FNone = 6'b000000;
   localparam logic [5:0] FLu   = 6'b110001;
   localparam logic [5:0] FRd   = 6'b000011;
   localparam logic [5:0] FAll  = 6'b111100;

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, rw;
      logic [1:0] src;
      logic       redir, mreq, mrdy;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [5:0] flags();
      return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 5'd0; ex_reg_write = 1'b0; ex_result_src = 2'b00;
      ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_load_use();
      ex_result_src = 2'b01; ex_reg_write = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
   endtask

   task automatic apply_vec(input vec_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
      ex_rd = v.rd; ex_reg_write = v.rw; ex_result_src = v.src;
      ex_redirect = v.redir; mem_req = v.mreq; mem_ready = v.mrdy;
   endtask

   initial begin
      //           name            rs1    rs2    rd     u1    u2    rw    src    redir mreq  mrdy  exp
      vecs[0]  = '{"lu_rs1",       5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FLu};
      vecs[1]  = '{"lu_rd_zero",   5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FNone};
      vecs[2]  = '{"lu_rs1_unused",5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FNone};
      vecs[3]  = '{"lu_rs2",       5'd1,  5'd9,  5'd9,  1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FLu};
      vecs[4]  = '{"lu_rs2_unused",5'd1,  5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FNone};
      vecs[5]  = '{"alu_src",      5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, FNone};
      vecs[6]  = '{"no_write",     5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, FNone};
      vecs[7]  = '{"src_10",       5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, FNone};
      vecs[8]  = '{"redir_over_lu",5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, FRd};
      vecs[9]  = '{"redir_only",   5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, FRd};
      vecs[10] = '{"memrdy_lu",    5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, FLu};
      vecs[11] = '{"memrdy_redir", 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, FRd};
      vecs[12] = '{"idle",         5'd3,  5'd4,  5'd7,  1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, FNone};

      // Reset: outputs quiet even with hazard and memory-wait inputs active.
      clear_inputs();
      rst_n = 1'b0;
      set_load_use();
      mem_req = 1'b1;
      @(negedge clk);
      check("rst_flags", 32'(flags()), 32'(FNone));
      next_edge();
      check("rst_flags_after_edge", 32'(flags()), 32'(FNone));
      rst_n = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      next_edge();

      for (int i = 0; i < 13; i++) begin
         apply_vec(vecs[i]);
         @(negedge clk);
         check(vecs[i].name, 32'(flags()), 32'(vecs[i].exp));
         check({vecs[i].name, "_state"}, 32'(state), 32'd0);
         next_edge();
      end

      // Load-use stalls one cycle; the bubble in EX then clears it.
      clear_inputs();
      set_load_use();
      @(negedge clk);
      check("lu_seq_stall", 32'(flags()), 32'(FLu));
      next_edge();
      ex_result_src = 2'b00; ex_reg_write = 1'b0; ex_rd = 5'd0;
      @(negedge clk);
      check("lu_seq_bubble", 32'(flags()), 32'(FNone));
      next_edge();

      // Memory wait with redirect and load-use pending; redirect wins in the first RUN cycle.
      clear_inputs();
      set_load_use();
      ex_redirect = 1'b1;
      mem_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         @(negedge clk);
         check($sformatf("wait_flags_%0d", k), 32'(flags()), 32'(FAll));
         check($sformatf("wait_state_%0d", k), 32'(state), (k == 0) ? 32'd0 : 32'd1);
         next_edge();
      end
      mem_req = 1'b0;
      @(negedge clk);
      check("wait_exit_flush", 32'(flags()), 32'(FRd));
      check("wait_exit_state", 32'(state), 32'd0);
      next_edge();

      // Timeout into ERR after WAIT_LIMIT wait cycles, sticky until reset.
      clear_inputs();
      mem_req = 1'b1;
      next_edge();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("to_state_%0d", k), 32'(state), 32'd1);
         check($sformatf("to_err_%0d", k), 32'(err), 32'd0);
         next_edge();
      end
      @(negedge clk);
      check("to_err_state", 32'(state), 32'd2);
      check("to_err_flag", 32'(err), 32'd1);
      check("to_err_flags", 32'(flags()), 32'(FAll));
      mem_req = 1'b0;
      mem_ready = 1'b1;
      ex_redirect = 1'b1;
      next_edge();
      @(negedge clk);
      check("err_sticky_state", 32'(state), 32'd2);
      check("err_sticky_flags", 32'(flags()), 32'(FAll));
      rst_n = 1'b0;
      @(negedge clk);
      check("err_rst_flags", 32'(flags()), 32'(FNone));
      next_edge();
      rst_n = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("err_rst_state", 32'(state), 32'd0);
      check("err_rst_err", 32'(err), 32'd0);

      // Reset mid-wait must also clear the counter: a fresh timeout takes the full four cycles.
      mem_req = 1'b1;
      next_edge();
      next_edge();
      rst_n = 1'b0;
      next_edge();
      rst_n = 1'b1;
      mem_req = 1'b0;
      @(negedge clk);
      check("midwait_rst_state", 32'(state), 32'd0);
      mem_req = 1'b1;
      for (int k = 0; k < 4; k++) next_edge();
      @(negedge clk);
      check("midwait_cnt_cleared", 32'(state), 32'd1);
      next_edge();
      @(negedge clk);
      check("midwait_timeout", 32'(state), 32'd2);
      rst_n = 1'b0;
      next_edge();
      rst_n = 1'b1;
      clear_inputs();

`ifdef HAZARD_PERF_CNT_EN
      set_load_use();
      next_edge();
      next_edge();
      clear_inputs();
      ex_redirect = 1'b1;
      next_edge();
      clear_inputs();
      mem_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         next_edge();
      end
      clear_inputs();
      next_edge();
      check("perf_stall", perf_stall_cnt, 32'd2);
      check("perf_flush", perf_flush_cnt, 32'd1);
      check("perf_wait", perf_wait_cnt, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
